// File: rtl/intellight_axil_if.sv
// AXI4-Lite bus bundle between the system master and the Intellight register front end.
interface intellight_axil_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/intellight_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the Q-learning core,
// with independent AW/W holding slots and a one-cycle write pulse per register.
module intellight_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  intellight_axil_if.slave              s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_q,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_q,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_q,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_q,
  output logic [3:0]                    reg_wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  logic [DW-1:0] regs [4];
  logic          aw_held, w_held;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] w_data_q;
  logic [NB-1:0] w_strb_q;
  logic          bvalid_q, rvalid_q;
  logic [DW-1:0] rdata_q;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_strb;

  assign s_axi.awready = !aw_held && !bvalid_q && !areset;
  assign s_axi.wready  = !w_held && !bvalid_q && !areset;
  assign s_axi.arready = !rvalid_q && !areset;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // A held slot takes priority; otherwise the live handshake supplies the value.
  assign commit  = (aw_hs || aw_held) && (w_hs || w_held);
  assign wr_idx  = aw_held ? aw_idx_q : s_axi.awaddr[3:2];
  assign wr_data = w_held ? w_data_q : s_axi.wdata;
  assign wr_strb = w_held ? w_strb_q : s_axi.wstrb;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        for (int k = 0; k < NB; k++)
          if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        reg_wr_pulse[wr_idx] <= 1'b1;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_axi.awaddr[3:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.wdata;
          w_strb_q <= s_axi.wstrb;
        end
        if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Reads sample regs before this cycle's write lands, so a same-address collision returns the old value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs[s_axi.araddr[3:2]];
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign reg0_q = regs[0];
  assign reg1_q = regs[1];
  assign reg2_q = regs[2];
  assign reg3_q = regs[3];

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
endmodule

// File: tb/tb_intellight_axil_regs.sv
// Self-checking bench for intellight_axil_regs: directed scenarios plus randomized
// traffic compared against a byte-merge register model.
module tb_intellight_axil_regs;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] r0, r1, r2, r3;
  logic [3:0]  pulse;

  intellight_axil_if bus();

  intellight_axil_regs dut (
    .aclk(aclk), .areset(areset), .s_axi(bus),
    .reg0_q(r0), .reg1_q(r1), .reg2_q(r2), .reg3_q(r3),
    .reg_wr_pulse(pulse)
  );

  always #5 aclk = ~aclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [4];
  int          exp_pulse [4];
  int          pulse_cnt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      default: return r3;
    endcase
  endfunction

  always @(negedge aclk)
    if (!areset)
      for (int i = 0; i < 4; i++) if (pulse[i]) pulse_cnt[i]++;

  // lag > 0: W leads AW by lag cycles; lag < 0: AW leads W.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lag, input int hold_b);
    int aw_start, w_start, idx;
    bit aw_done, w_done;
    aw_done = 0; w_done = 0;
    idx = int'(addr[3:2]);
    aw_start = (lag > 0) ? lag : 0;
    w_start  = (lag < 0) ? -lag : 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awprot = 3'($urandom);
    bus.bready = (hold_b == 0);
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      @(posedge aclk); #1;
      bus.awvalid = !aw_done && cyc >= aw_start;
      bus.wvalid  = !w_done && cyc >= w_start;
      @(negedge aclk);
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      if (w_done && !aw_done && !bus.wvalid) check("wready_while_held", 32'(bus.wready), 0);
      if (aw_done && !w_done && !bus.awvalid) check("awready_while_held", 32'(bus.awready), 0);
    end
    @(posedge aclk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    if (!(aw_done && w_done)) begin
      check("wr_hs_timeout", {30'b0, aw_done, w_done}, 32'h3);
      bus.bready = 1;
      return;
    end
    for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    exp_pulse[idx]++;
    @(negedge aclk);
    check("bvalid_commit", 32'(bus.bvalid), 1);
    check("bresp", 32'(bus.bresp), 0);
    check("reg_after_wr", dut_reg(idx), model[idx]);
    check("wr_pulse", 32'(pulse), 32'(4'b1 << idx));
    for (int i = 0; i < hold_b; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check("bvalid_stall", 32'(bus.bvalid), 1);
      check("no_accept_stall", {30'b0, bus.awready, bus.wready}, 0);
    end
    if (hold_b > 0) begin
      @(posedge aclk); #1;
      bus.bready = 1;
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    check("bvalid_clear", 32'(bus.bvalid), 0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int hold_r);
    bit done;
    done = 0;
    bus.araddr = addr;
    bus.arprot = 3'($urandom);
    bus.rready = (hold_r == 0);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(posedge aclk); #1;
      bus.arvalid = 1;
      @(negedge aclk);
      if (bus.arready) done = 1;
    end
    @(posedge aclk); #1;
    bus.arvalid = 0;
    if (!done) begin
      check("rd_hs_timeout", 32'(done), 1);
      bus.rready = 1;
      return;
    end
    @(negedge aclk);
    check("rvalid", 32'(bus.rvalid), 1);
    check("rdata", bus.rdata, exp);
    check("rresp", 32'(bus.rresp), 0);
    for (int i = 0; i < hold_r; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check("rvalid_hold", 32'(bus.rvalid), 1);
      check("rdata_hold", bus.rdata, exp);
    end
    if (hold_r > 0) begin
      @(posedge aclk); #1;
      bus.rready = 1;
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    check("rvalid_clear", 32'(bus.rvalid), 0);
    check("arready_again", 32'(bus.arready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pre;
    logic [3:0]  a;
    for (int i = 0; i < 4; i++) begin
      model[i] = '0; exp_pulse[i] = 0; pulse_cnt[i] = 0;
    end
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 1;

    #100;
    check("rst_regs", r0 | r1 | r2 | r3, 0);
    check("rst_pulse", 32'(pulse), 0);
    check("rst_valids", {30'b0, bus.bvalid, bus.rvalid}, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_readys", {29'b0, bus.awready, bus.wready, bus.arready}, 0);
    #103 areset = 0;
    @(negedge aclk);
    check("readys_after_rst", {29'b0, bus.awready, bus.wready, bus.arready}, 3'b111);

    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'(i + 1), 0);
    for (int i = 0; i < 4; i++) check("burst_pulse_cnt", 32'(pulse_cnt[i]), 1);

    axi_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0);
    axi_write(4'h5, 32'h11223344, 4'b0101, 0, 0);
    check("strobe_merge", r1, 32'hAA22CC44);

    axi_write(4'h8, 32'h5A, 4'hF, 3, 4);
    axi_write(4'hE, 32'hC0FFEE00, 4'hF, -2, 1);

    axi_write(4'h8, 32'h7, 4'hF, 0, 0);
    pre = model[2];
    fork
      axi_write(4'h8, 32'h9, 4'hF, 0, 0);
      axi_read(4'h8, pre, 3);
    join
    check("collision_reg2", r2, 32'h9);

    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 2)));
      else
        axi_read(a, model[a[3:2]], int'($urandom_range(0, 2)));
    end

    @(posedge aclk); #1;
    bus.awaddr = 4'h0; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    bus.araddr = 4'h4; bus.bready = 0; bus.rready = 0;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
    @(negedge aclk);
    check("mr_readys", {29'b0, bus.awready, bus.wready, bus.arready}, 3'b111);
    pre = model[1];
    @(posedge aclk); #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    model[0] = 32'hDEADBEEF;
    exp_pulse[0]++;
    @(negedge aclk);
    check("mr_valids_before", {30'b0, bus.bvalid, bus.rvalid}, 2'b11);
    check("mr_rdata", bus.rdata, pre);
    #2 areset = 1;
    #1;
    check("mr_valids_after", {30'b0, bus.bvalid, bus.rvalid}, 0);
    check("mr_regs_clear", r0 | r1 | r2 | r3, 0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(posedge aclk); #1;
    areset = 0; bus.bready = 1; bus.rready = 1;
    @(negedge aclk);
    check("mr_readys_after", {29'b0, bus.awready, bus.wready, bus.arready}, 3'b111);
    axi_read(4'h0, model[0], 0);

    for (int i = 0; i < 4; i++) check("pulse_cnt_total", 32'(pulse_cnt[i]), 32'(exp_pulse[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
